lanczos_phase_ctrl: RTL

//  Per-line sequencer for the horizontal Lanczos scaler. For each output pixel it computes the

---
 rtl/lanczos_phase_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/lanczos_phase_ctrl.sv
// Per-line phase sequencer for the horizontal Lanczos scaler. It walks the source position in
// fixed point, meters source pixels into the 6-tap window, and issues one phase request per output pixel.
module lanczos_phase_ctrl #(
    parameter int STEP   = 4096,
    parameter int FRAC_W = $clog2(STEP),
    parameter int DX_W   = $clog2(STEP / 4),
    parameter int W_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W_W-1:0]        src_width,
    input  logic [W_W-1:0]        dst_width,
    input  logic [W_W+FRAC_W-1:0] step,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [DX_W-1:0]       dx,
    output logic                  dx_valid,
    input  logic                  dx_ready,
    output logic                  dx_last,
    output logic                  coe_valid,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    localparam int POS_W = W_W + FRAC_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
    // valid/ready outputs depend only on registered state, never on the partner's ready/valid.

    state_t             state_q, state_d;
    logic [W_W-1:0]     src_w_q, src_w_d;
    logic [W_W-1:0]     dst_w_q, dst_w_d;
    logic [POS_W-1:0]   step_q, step_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [W_W-1:0]     src_cnt_q, src_cnt_d;
    logic [W_W-1:0]     dst_cnt_q, dst_cnt_d;
    logic               coe_valid_q, coe_valid_d;

    logic [W_W-1:0]     pos_int;
    logic [W_W:0]       need_wide;
    logic [W_W-1:0]     need;

    // Window needs taps up to floor(p)+3, i.e. floor(p)+4 pixels, clipped at the right edge.
    always_comb begin
        pos_int   = pos_q[POS_W-1:FRAC_W];
        need_wide = {1'b0, pos_int} + (W_W+1)'(4);
        if (need_wide > {1'b0, src_w_q}) begin
            need = src_w_q;
        end else begin
            need = need_wide[W_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        src_w_d     = src_w_q;
        dst_w_d     = dst_w_q;
        step_d      = step_q;
        pos_d       = pos_q;
        src_cnt_d   = src_cnt_q;
        dst_cnt_d   = dst_cnt_q;
        src_ready   = 1'b0;
        dx_valid    = 1'b0;
        dx          = '0;
        dx_last     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_w_d   = src_width;
                    dst_w_d   = dst_width;
                    step_d    = step;
                    pos_d     = '0;
                    src_cnt_d = '0;
                    dst_cnt_d = '0;
                    if ((src_width == '0) || (dst_width == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                busy      = 1'b1;
                src_ready = (src_cnt_q < need);
                dx_valid  = (src_cnt_q >= need);
                dx        = pos_q[FRAC_W-1:FRAC_W-DX_W];
                dx_last   = (dst_cnt_q == (dst_w_q - W_W'(1)));
                if (src_valid && src_ready) begin
                    src_cnt_d = src_cnt_q + W_W'(1);
                end
                if (dx_valid && dx_ready) begin
                    pos_d     = pos_q + step_q;
                    dst_cnt_d = dst_cnt_q + W_W'(1);
                    if (dx_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // Flush source pixels the window never needed so the line buffer ends aligned.
                busy      = 1'b1;
                src_ready = (src_cnt_q < src_w_q);
                if (src_valid && src_ready) begin
                    src_cnt_d = src_cnt_q + W_W'(1);
                end
                if (src_cnt_q == src_w_q) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        coe_valid_d = dx_valid && dx_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_w_q     <= '0;
            dst_w_q     <= '0;
            step_q      <= '0;
            pos_q       <= '0;
            src_cnt_q   <= '0;
            dst_cnt_q   <= '0;
            coe_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_w_q     <= src_w_d;
            dst_w_q     <= dst_w_d;
            step_q      <= step_d;
            pos_q       <= pos_d;
            src_cnt_q   <= src_cnt_d;
            dst_cnt_q   <= dst_cnt_d;
            coe_valid_q <= coe_valid_d;
        end
    end

    assign coe_valid = coe_valid_q;
    assign dbg_state = state_q;

endmodule
